mult_hilo_ctrl: RTL and testbench

- Sequencing and result stage wrapped around the combinational 32x32 signed multiplier.
- On a start request it registers the operands and drives them, stable, into the multiplier. It waits a fixed number of settle cycles, then captures {out_high, out_low} into the architectural HI/LO registers.
- Provides a busy/done handshake to the CPU control FSM, plus mthi/mtlo write ports. HI/LO are read continuously (mfhi/mflo).

---
 rtl/mult_pkg.sv | 17 +
 rtl/mult_hilo_ctrl_if.sv | 31 +++
 rtl/mult_hilo_ctrl_hilo_regs.sv | 46 ++++
 rtl/mult_hilo_ctrl.sv | 101 ++++++++++
 tb/tb_mult_hilo_ctrl.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/mult_pkg.sv
// Shared types and defaults for the HI/LO multiply sequencer.
package mult_pkg;

  localparam int DEF_DATA_W        = 32;
  localparam int DEF_SETTLE_CYCLES = 4;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  // The settle counter never needs to hold more than SETTLE_CYCLES-1, but it always has at least one bit.
  function automatic int cnt_width(input int settle);
    return (settle > 1) ? $clog2(settle) : 1;
  endfunction

endpackage

// File: rtl/mult_hilo_ctrl_if.sv
// CPU-side handshake, mthi/mtlo, HI/LO readback and multiplier operand/result bus.
interface mult_hilo_ctrl_if #(
  parameter int DATA_W = mult_pkg::DEF_DATA_W
);

  logic              start;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              wr_hi;
  logic              wr_lo;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] mult_a;
  logic [DATA_W-1:0] mult_b;
  logic [DATA_W-1:0] mult_hi;
  logic [DATA_W-1:0] mult_lo;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  modport master (
    output start, op_a, op_b, wr_hi, wr_lo, wr_data, mult_hi, mult_lo,
    input  mult_a, mult_b, busy, done, hi, lo
  );

  modport slave (
    input  start, op_a, op_b, wr_hi, wr_lo, wr_data, mult_hi, mult_lo,
    output mult_a, mult_b, busy, done, hi, lo
  );

endinterface

// File: rtl/mult_hilo_ctrl_hilo_regs.sv
// Architectural HI/LO register pair: loaded by a multiply capture or by mthi/mtlo.
module hilo_regs #(
  parameter int DATA_W = mult_pkg::DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic [DATA_W-1:0] hi_in,
  input  logic [DATA_W-1:0] lo_in,
  input  logic              wr_hi,
  input  logic              wr_lo,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;

  // A product capture wins over a coincident mthi/mtlo.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (en) begin
      hi_d = hi_in;
      lo_d = lo_in;
    end else begin
      if (wr_hi) hi_d = wr_data;
      if (wr_lo) lo_d = wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: rtl/mult_hilo_ctrl.sv
// Sequences a multiply: latches operands, waits SETTLE_CYCLES, then captures the product into HI/LO.
module mult_hilo_ctrl
  import mult_pkg::*;
#(
  parameter int DATA_W        = DEF_DATA_W,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input logic             clk,
  input logic             reset_n,
  mult_hilo_ctrl_if.slave bus
);

  localparam int               CNT_W    = cnt_width(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("mult_hilo_ctrl: SETTLE_CYCLES must be at least 1");
  end

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] mult_a_q, mult_a_d;
  logic [DATA_W-1:0] mult_b_q, mult_b_d;
  logic              done_q, done_d;
  logic              capture;
  logic              idle;
  logic [DATA_W-1:0] hi_w;
  logic [DATA_W-1:0] lo_w;

  assign idle = (state_q == IDLE);

  // The capture edge is also the WAIT exit, so the done cycle is already IDLE and may accept a new start.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mult_a_d = mult_a_q;
    mult_b_d = mult_b_q;
    done_d   = 1'b0;
    capture  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          mult_a_d = bus.op_a;
          mult_b_d = bus.op_b;
          cnt_d    = CNT_LOAD;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          capture = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mult_a_q <= '0;
      mult_b_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mult_a_q <= mult_a_d;
      mult_b_q <= mult_b_d;
      done_q   <= done_d;
    end
  end

  hilo_regs #(
    .DATA_W(DATA_W)
  ) u_hilo_regs (
    .clk    (clk),
    .reset_n(reset_n),
    .en     (capture),
    .hi_in  (bus.mult_hi),
    .lo_in  (bus.mult_lo),
    .wr_hi  (bus.wr_hi && idle),
    .wr_lo  (bus.wr_lo && idle),
    .wr_data(bus.wr_data),
    .hi     (hi_w),
    .lo     (lo_w)
  );

  assign bus.mult_a = mult_a_q;
  assign bus.mult_b = mult_b_q;
  assign bus.busy   = !idle;
  assign bus.done   = done_q;
  assign bus.hi     = hi_w;
  assign bus.lo     = lo_w;

endmodule

// File: tb/tb_mult_hilo_ctrl.sv
// Directed bench for mult_hilo_ctrl with a golden 32x32 signed multiplier and a cycle-level reference model.
module tb_mult_hilo_ctrl;

  localparam int DW     = 32;
  localparam int SETTLE = 4;

  logic clk;
  logic reset_n;

  int assert_count;
  int fail_count;

  mult_hilo_ctrl_if #(.DATA_W(DW)) bus ();

  mult_hilo_ctrl #(
    .DATA_W       (DW),
    .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return 64'(sa * sb);
  endfunction

  // Stand-in for the combinational multiplier sitting outside the block.
  always_comb begin
    logic [63:0] p;
    p = mul64(bus.mult_a, bus.mult_b);
    bus.mult_hi = p[63:32];
    bus.mult_lo = p[31:0];
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic [31:0] a, input logic [31:0] b,
                               input logic wh, input logic wl, input logic [31:0] wd);
    @(negedge clk);
    bus.start   = st;
    bus.op_a    = a;
    bus.op_b    = b;
    bus.wr_hi   = wh;
    bus.wr_lo   = wl;
    bus.wr_data = wd;
  endtask

  // Reference model: a count of edges still to go before the product lands, plus the architectural values.
  int          m_left;
  logic [31:0] m_a, m_b, m_hi, m_lo;
  logic        m_done;

  always @(posedge clk) begin
    logic [63:0] prod;
    if (!reset_n) begin
      m_left = 0;
      m_a = '0; m_b = '0; m_hi = '0; m_lo = '0;
      m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_left == 0) begin
        if (bus.wr_hi) m_hi = bus.wr_data;
        if (bus.wr_lo) m_lo = bus.wr_data;
        if (bus.start) begin
          m_a = bus.op_a;
          m_b = bus.op_b;
          m_left = SETTLE;
        end
      end else begin
        if (bus.wr_hi || bus.wr_lo)
          $display("[TB] note: mthi/mtlo issued while busy at %0t, expected to be ignored", $time);
        m_left = m_left - 1;
        if (m_left == 0) begin
          prod = mul64(m_a, m_b);
          m_hi = prod[63:32];
          m_lo = prod[31:0];
          m_done = 1'b1;
        end
      end
    end
    #1;
    checkOutput("model busy", 32'(bus.busy), 32'(m_left != 0));
    checkOutput("model done", 32'(bus.done), 32'(m_done));
    checkOutput("model hi", bus.hi, m_hi);
    checkOutput("model lo", bus.lo, m_lo);
    checkOutput("model mult_a", bus.mult_a, m_a);
    checkOutput("model mult_b", bus.mult_b, m_b);
  end

  // Start a multiply, then pin latency, busy length and the captured HI/LO with literal values.
  task automatic runMult(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int cyc;
    int busy_cycles;
    cyc = 0;
    busy_cycles = 0;
    applyStimulus(1'b1, a, b, 1'b0, 1'b0, 32'h0);
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) bus.start = 1'b0;
      if (bus.busy) busy_cycles++;
    end while (!bus.done && cyc < 20);
    checkOutput({tag, " latency"}, 32'(cyc), 32'(SETTLE + 1));
    checkOutput({tag, " busy cycles"}, 32'(busy_cycles), 32'(SETTLE));
    checkOutput({tag, " hi"}, bus.hi, exp_hi);
    checkOutput({tag, " lo"}, bus.lo, exp_lo);
    @(negedge clk);
    checkOutput({tag, " done clears"}, 32'(bus.done), 32'h0);
  endtask

  task automatic waitDone(input string tag);
    int cyc;
    cyc = 0;
    while (!bus.done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput({tag, " done seen"}, 32'(bus.done), 32'h1);
  endtask

  initial begin
    int          done_count;
    int          busy_count;
    logic [31:0] captured [4];

    assert_count = 0;
    fail_count   = 0;
    reset_n      = 1'b0;
    bus.start = 1'b0; bus.op_a = '0; bus.op_b = '0;
    bus.wr_hi = 1'b0; bus.wr_lo = 1'b0; bus.wr_data = '0;

    repeat (2) @(negedge clk);
    checkOutput("reset busy", 32'(bus.busy), 32'h0);
    checkOutput("reset done", 32'(bus.done), 32'h0);
    checkOutput("reset hi", bus.hi, 32'h0);
    checkOutput("reset lo", bus.lo, 32'h0);
    checkOutput("reset mult_a", bus.mult_a, 32'h0);
    checkOutput("reset mult_b", bus.mult_b, 32'h0);
    reset_n = 1'b1;

    runMult("3x5", 32'd3, 32'd5, 32'h0000_0000, 32'h0000_000F);
    runMult("m1x1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    runMult("min_sq", 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    runMult("m7x6", 32'hFFFF_FFF9, 32'd6, 32'hFFFF_FFFF, 32'hFFFF_FFD6);

    // Start held high: the done cycle is also an accept cycle, so captures come every SETTLE+1 edges.
    done_count = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (k > 0 && bus.done) begin
        if (done_count < 4) captured[done_count] = bus.lo;
        done_count++;
      end
      bus.start = 1'b1;
      bus.op_a  = 32'(k + 2);
      bus.op_b  = 32'd3;
    end
    @(negedge clk);
    if (bus.done) begin
      if (done_count < 4) captured[done_count] = bus.lo;
      done_count++;
    end
    bus.start = 1'b0;
    checkOutput("held start captures", 32'(done_count), 32'd3);
    checkOutput("held start product 0", captured[0], 32'd6);
    checkOutput("held start product 1", captured[1], 32'd21);
    checkOutput("held start product 2", captured[2], 32'd36);

    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h1234_5678);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("mthi hi", bus.hi, 32'h1234_5678);
    checkOutput("mthi lo kept", bus.lo, 32'd36);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hCAFE_F00D);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("mtlo lo", bus.lo, 32'hCAFE_F00D);
    checkOutput("mtlo hi kept", bus.hi, 32'h1234_5678);

    applyStimulus(1'b1, 32'd4, 32'd5, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 32'd9, 32'd9, 1'b1, 1'b0, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'h0);
    checkOutput("busy mthi ignored", bus.hi, 32'h1234_5678);
    waitDone("busy mthi");
    checkOutput("busy mthi product hi", bus.hi, 32'h0);
    checkOutput("busy mthi product lo", bus.lo, 32'd20);

    applyStimulus(1'b1, 32'd9, 32'd9, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checkOutput("midwait reset busy", 32'(bus.busy), 32'h0);
    checkOutput("midwait reset done", 32'(bus.done), 32'h0);
    checkOutput("midwait reset hi", bus.hi, 32'h0);
    checkOutput("midwait reset lo", bus.lo, 32'h0);
    checkOutput("midwait reset mult_a", bus.mult_a, 32'h0);
    checkOutput("midwait reset mult_b", bus.mult_b, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    done_count = 0;
    busy_count = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.done) done_count++;
      if (bus.busy) busy_count++;
    end
    checkOutput("no done after reset", 32'(done_count), 32'h0);
    checkOutput("no busy after reset", 32'(busy_count), 32'h0);
    runMult("6x7 after reset", 32'd6, 32'd7, 32'h0, 32'd42);

    applyStimulus(1'b1, 32'd2, 32'd7, 1'b0, 1'b1, 32'hAAAA_0000);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'h0);
    checkOutput("start+mtlo lo during busy", bus.lo, 32'hAAAA_0000);
    checkOutput("start+mtlo busy", 32'(bus.busy), 32'h1);
    waitDone("start+mtlo");
    checkOutput("start+mtlo final lo", bus.lo, 32'h0000_000E);
    checkOutput("start+mtlo final hi", bus.hi, 32'h0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
